timeslot_scheduler: RTL and testbench
=====================================

TIMESLOT_SCHEDULER -- requirements
Module: timeslot_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the slot resource, range 2..16.
REQ-002 Parameter SLOT_W, default 8: width of the slot-length field and of the internal slot counter.
REQ-003 Constant OWN_W SHALL be $clog2(NREQ).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  permits new grants; does not abort an active slot.
REQ-007 req  input  NREQ  per-requester level request; bit i belongs to requester i.
REQ-008 slot_len  input  SLOT_W  grant duration in cycles; a value of 0 SHALL be treated as 1.
REQ-009 grant  output  NREQ  one-hot grant, or all zero when no slot is active.
REQ-010 owner  output  OWN_W  index of the current or most recent grantee.
REQ-011 busy  output  1  high while in GRANT or GUARD.
REQ-012 slot_done  output  1  one-cycle pulse on the cycle after a slot runs its full length.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT and GUARD.
REQ-014 IDLE: if enable and req is non-zero, select a winner and enter GRANT on the next edge; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at (rr_ptr+1) mod NREQ, and the first set req bit wins.
REQ-016 On entry to GRANT: grant[winner]=1, owner=winner, rr_ptr=winner, slot counter=0, and slot_len is latched into len_q (0 becomes 1).
REQ-017 Changes to slot_len during GRANT SHALL have no effect until the next grant.
REQ-018 GRANT: the slot counter increments by 1 per cycle and is SLOT_W bits wide, modulo 2^SLOT_W.
REQ-019 GRANT expiry: when count==len_q-1 and req[owner]=1, the next edge SHALL enter GUARD, with grant=0 and slot_done=1 for that one cycle.
REQ-020 With req held, grant SHALL stay high for exactly len_q cycles.
REQ-021 GRANT early release: if req[owner]=0 in any GRANT cycle, the next edge SHALL enter GUARD with grant=0 and slot_done=0.
REQ-022 If expiry and release occur in the same cycle, release SHALL take priority, so slot_done=0.
REQ-023 GUARD: exactly one cycle with grant=0, then IDLE.
REQ-024 The minimum gap between two grants SHALL be 2 cycles (GUARD, then IDLE).
REQ-025 Deasserting enable during GRANT or GUARD SHALL let the sequence finish; it only blocks arbitration in IDLE.
REQ-026 Requests from non-owners during GRANT or GUARD SHALL be ignored; no queuing.
REQ-027 owner SHALL hold its value through GUARD and IDLE until the next grant.
REQ-028 grant SHALL never have more than one bit set; busy=1 exactly when the state is GRANT or GUARD.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 Asserting reset SHALL immediately set: state=IDLE, grant=0, owner=0, busy=0, slot_done=0, count=0, len_q=1.
REQ-031 On reset, rr_ptr SHALL be set to NREQ-1, so the first search starts at requester 0.
REQ-032 Reset during GRANT SHALL drop grant asynchronously, with no slot_done pulse.
REQ-033 The first grant is possible on the first edge after reset deasserts, and is visible in the following cycle.

Structure
REQ-034 The state enum (IDLE/GRANT/GUARD) SHALL reside in the shared package timeslot_pkg.
REQ-035 The default NREQ and SLOT_W constants SHALL also reside in timeslot_pkg.
REQ-036 The slot counter SHALL be a sub-module, slot_counter, with clk, reset, clear, enable, a terminal-value input and a terminal-count output.
REQ-037 Round-robin selection SHALL be a function inside timeslot_scheduler, not a separate module.

Verification
REQ-038 Single requester: NREQ=4, slot_len=3, req=0001 held -> grant=0001 for 3 cycles, slot_done pulses once, 2 idle cycles, then grant repeats.
REQ-039 Rotation: req=1111 held, slot_len=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with owner 0,1,2,3,0.
REQ-040 Early release: slot_len=10, req[2] drops in grant cycle 4 -> grant=0 from the next cycle, no slot_done, busy falls 2 cycles after req drops.
REQ-041 Zero and maximum length: slot_len=0 -> grant lasts 1 cycle; slot_len=255 -> grant lasts 255 cycles and slot_done fires once.
REQ-042 Enable gating: enable=0 mid-slot with req=0011 -> current slot completes and no further grant occurs until enable returns to 1.
REQ-043 Reset mid-grant: assert reset in grant cycle 2 -> grant=0 and owner=0 immediately; after release with req=1000, the first grant goes to requester 3.

Source files
------------

// File: rtl/timeslot_pkg.sv
// Shared types and default sizing for the time-slot scheduler.
package timeslot_pkg;

  localparam int unsigned DefaultNreq  = 4;
  localparam int unsigned DefaultSlotW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGuard
  } ts_state_e;

endpackage

// File: rtl/timeslot_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface timeslot_scheduler_if #(
  parameter int unsigned NREQ   = timeslot_pkg::DefaultNreq,
  parameter int unsigned SLOT_W = timeslot_pkg::DefaultSlotW
) ();

  localparam int unsigned OWN_W = $clog2(NREQ);

  logic              enable;
  logic [NREQ-1:0]   req;
  logic [SLOT_W-1:0] slot_len;
  logic [NREQ-1:0]   grant;
  logic [OWN_W-1:0]  owner;
  logic              busy;
  logic              slot_done;

  modport master (
    output enable, req, slot_len,
    input  grant, owner, busy, slot_done
  );

  modport slave (
    input  enable, req, slot_len,
    output grant, owner, busy, slot_done
  );

endinterface

// File: rtl/slot_counter.sv
// Slot-length counter: counts while enabled, flags when it sits on the terminal value.
module slot_counter import timeslot_pkg::*; #(
  parameter int unsigned SLOT_W = DefaultSlotW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [SLOT_W-1:0] term,
  output logic              tc
);

  logic [SLOT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + SLOT_W'(1);
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/timeslot_scheduler.sv
// Round-robin time-slot scheduler: one requester owns the resource for up to slot_len
// cycles, followed by a one-cycle guard gap.
module timeslot_scheduler import timeslot_pkg::*; #(
  parameter int unsigned NREQ   = DefaultNreq,
  parameter int unsigned SLOT_W = DefaultSlotW
) (
  input  logic                 clk,
  input  logic                 reset,
  timeslot_scheduler_if.slave  bus
);

  localparam int unsigned OWN_W = $clog2(NREQ);

  ts_state_e         state_q;
  logic [NREQ-1:0]   grant_q;
  logic [OWN_W-1:0]  owner_q;
  logic [OWN_W-1:0]  rr_ptr_q;
  logic [OWN_W-1:0]  winner;
  logic              busy_q;
  logic              done_q;
  logic [SLOT_W-1:0] len_q;
  logic              tc;

  // First set request found searching upward from ptr+1, wrapping at NREQ.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [OWN_W-1:0] ptr);
    logic [OWN_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && r[idx[OWN_W-1:0]]) begin
        pick  = idx[OWN_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(bus.req, rr_ptr_q);

  slot_counter #(
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != StGrant),
    .enable (state_q == StGrant),
    .term   (len_q - SLOT_W'(1)),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= OWN_W'(NREQ - 1);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= SLOT_W'(1);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.enable && (|bus.req)) begin
            state_q  <= StGrant;
            grant_q  <= NREQ'(1) << winner;
            owner_q  <= winner;
            rr_ptr_q <= winner;
            busy_q   <= 1'b1;
            len_q    <= (bus.slot_len == '0) ? SLOT_W'(1) : bus.slot_len;
          end
        end
        StGrant: begin
          // Release beats expiry, so a simultaneous drop never reports slot_done.
          if (!bus.req[owner_q]) begin
            state_q <= StGuard;
            grant_q <= '0;
          end else if (tc) begin
            state_q <= StGuard;
            grant_q <= '0;
            done_q  <= 1'b1;
          end
        end
        StGuard: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.slot_done = done_q;

endmodule

// File: tb/tb_timeslot_scheduler.sv
// Directed and randomized bench for timeslot_scheduler, checked against a slot-countdown model.
module tb_timeslot_scheduler;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned SLOT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timeslot_scheduler_if #(.NREQ(NREQ), .SLOT_W(SLOT_W)) bus ();

  timeslot_scheduler #(
    .NREQ   (NREQ),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cycles of grant left, guard/idle gap left, owner, last winner, done pulse.
  int m_left;
  int m_gap;
  int m_owner;
  int m_ptr;
  bit m_done;

  task automatic model_reset();
    m_left  = 0;
    m_gap   = 0;
    m_owner = 0;
    m_ptr   = NREQ - 1;
    m_done  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input logic [NREQ-1:0] r, input int len);
    m_done = 1'b0;
    if (m_left > 0) begin
      if (!r[m_owner]) begin
        m_left = 0;
        m_gap  = 1;
      end else if (m_left == 1) begin
        m_left = 0;
        m_gap  = 1;
        m_done = 1'b1;
      end else begin
        m_left--;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (en && r != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (r[i]) begin
          m_owner = i;
          break;
        end
      end
      m_ptr  = m_owner;
      m_left = (len == 0) ? 1 : len;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("grant", 32'(bus.grant), (m_left > 0) ? (32'd1 << m_owner) : 32'd0);
    check("owner", 32'(bus.owner), 32'(m_owner));
    check("busy", 32'(bus.busy), 32'((m_left > 0) || (m_gap > 0)));
    check("slot_done", 32'(bus.slot_done), 32'(m_done));
  endtask

  task automatic cycle(input bit en, input logic [NREQ-1:0] r, input int len);
    bus.enable   = en;
    bus.req      = r;
    bus.slot_len = len[SLOT_W-1:0];
    @(posedge clk);
    model_edge(en, r, len);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit               e;
    logic [NREQ-1:0]  r;
    int               l;
    int               n;

    bus.enable   = 1'b1;
    bus.req      = 4'b1111;
    bus.slot_len = 8'd3;
    model_reset();

    // Reset with requests pending: nothing may be granted.
    #1 reset = 1'b1;
    #1 check_outputs();
    repeat (2) begin
      @(posedge clk);
      #1 check_outputs();
    end
    reset = 1'b0;

    // Single requester, len 3, held: first grant right after reset release.
    repeat (14) cycle(1'b1, 4'b0001, 3);

    // Full rotation with len 1.
    repeat (20) cycle(1'b1, 4'b1111, 1);
    repeat (3) cycle(1'b1, 4'b0000, 1);

    // Early release in grant cycle 4 of a len-10 slot.
    repeat (4) cycle(1'b1, 4'b0100, 10);
    repeat (4) cycle(1'b1, 4'b0000, 10);

    // Zero length behaves as one cycle; maximum length 255.
    repeat (6) cycle(1'b1, 4'b0001, 0);
    repeat (3) cycle(1'b1, 4'b0000, 0);
    repeat (262) cycle(1'b1, 4'b0010, 255);
    repeat (3) cycle(1'b1, 4'b0000, 255);

    // slot_len changes during a grant must not shorten the latched length.
    cycle(1'b1, 4'b0001, 6);
    repeat (10) cycle(1'b1, 4'b0001, 2);
    repeat (3) cycle(1'b1, 4'b0000, 2);

    // Enable drops mid-slot: slot completes, no new grant until enable returns.
    repeat (2) cycle(1'b1, 4'b0011, 4);
    repeat (12) cycle(1'b0, 4'b0011, 4);
    repeat (8) cycle(1'b1, 4'b0011, 4);
    repeat (3) cycle(1'b1, 4'b0000, 4);

    // Reset in grant cycle 2, then requester 3 gets the first grant.
    cycle(1'b1, 4'b0001, 5);
    cycle(1'b1, 4'b0001, 5);
    #3 reset = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    reset = 1'b0;
    repeat (6) cycle(1'b1, 4'b1000, 2);

    // Randomized bursts.
    repeat (100) begin
      e = ($urandom_range(0, 4) != 0);
      r = NREQ'($urandom);
      l = (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
      n = int'($urandom_range(1, 8));
      repeat (n) cycle(e, r, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
